alu_op_issue: RTL and testbench
===============================

// Module: alu_op_issue
// PURPOSE
//  Upstream issue stage for the 16-bit ALU: accepts {A, B, command} ops over a valid/ready
//  handshake, buffers them in a small FIFO, and presents one op at a time to the ALU inputs.
//  Screens each op at entry: illegal command 7 and divide/modulo by zero are rejected, never issued.
//  Sits between the operand source (decode/register read) and the ALU.
// PARAMETERS
//  DEPTH  4   FIFO entries; power of two, >= 2
//  AW     2   pointer width, log2(DEPTH)
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-high reset
//  in_valid   in   1   upstream op valid
//  in_ready   out  1   op accepted this cycle when in_valid && in_ready
//  in_a       in   16  operand A
//  in_b       in   16  operand B
//  in_cmd     in   3   ALU command (0 ADD,1 SUB,2 AND,3 MP0,4 MP1,5 DIV,6 MOD)
//  alu_valid  out  1   alu_a/alu_b/alu_cmd hold a live op
//  alu_ready  in   1   ALU side consumes the op this cycle when alu_valid && alu_ready
//  alu_a      out  16  operand A to ALU
//  alu_b      out  16  operand B to ALU
//  alu_cmd    out  3   command to ALU
//  err_illegal out 1   one-cycle pulse: accepted op had in_cmd==7, dropped
//  err_divzero out 1   one-cycle pulse: accepted op was DIV/MOD with in_b[15:1]==0, dropped
//  occupancy  out  AW+1 number of buffered ops
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-transfer): pointers, occupancy=0, alu_valid=0,
//    alu_a=alu_b=0, alu_cmd=0, err_*=0; in_ready=1 as soon as reset deasserts. Buffered ops lost.
//  - in_ready = (occupancy != DEPTH); derived from registered state only, no comb path
//    from alu_ready. A full FIFO does not accept even if a pop occurs the same cycle.
//  - Accept check on handshake: cmd==7 -> err_illegal pulse next cycle, not enqueued;
//    cmd in {5,6} and in_b[15:1]==0 -> err_divzero pulse next cycle, not enqueued.
//    Operand test uses bits [15:1], matching the ALU's datapath field. Rejected ops still
//    complete the handshake (upstream is not stalled).
//  - Enqueue latency: op accepted in cycle N into empty FIFO -> alu_valid=1 in cycle N+1.
//  - alu_a/alu_b/alu_cmd are registered and stable while alu_valid && !alu_ready.
//  - Pop on alu_valid && alu_ready; next entry (if any) appears the following cycle with no
//    bubble; alu_valid drops to 0 when the last entry is popped and nothing is enqueued.
//  - Simultaneous push+pop (not full): occupancy unchanged, order preserved (strict FIFO).
//  - Pointers wrap modulo DEPTH; occupancy never exceeds DEPTH nor underflows.
//  - alu_valid == (occupancy != 0) at all times.
//  - Outputs keep last value when alu_valid=0 (not cleared) to avoid toggling the ALU.
// STRUCTURE
//  - Shared package alu_pkg: command encodings CMD_ADD..CMD_MOD, CMD_ILLEGAL=3'd7,
//    DATA_W=16, CMD_W=3, op struct/bundle {a,b,cmd} (35 bits).
//  - Sub-module alu_op_fifo: generic DEPTH x 35-bit synchronous FIFO with registered head,
//    full/empty/count; alu_op_issue adds screening, error pulses and the handshake mapping.
// TESTING
//  1 Reset mid-stream: 3 ops queued, assert reset -> occupancy=0, alu_valid=0, in_ready=1,
//    alu_a=0 immediately (async).
//  2 Single op A=16'h0006,B=16'h0004,cmd=0 into empty, alu_ready=1 -> alu_valid=1 next cycle
//    with alu_a=0006,alu_b=0004,alu_cmd=0; alu_valid=0 the cycle after.
//  3 Backpressure: alu_ready=0, push 5 ops -> in_ready=0 after 4th, occupancy=4; release ->
//    ops emerge in order one per cycle, no bubble, then alu_valid=0.
//  4 cmd=5 with B=16'h0001 (B[15:1]=0) -> err_divzero=1 one cycle, occupancy unchanged;
//    cmd=6 with B=16'h0002 -> enqueued normally.
//  5 cmd=7 any operands -> err_illegal=1 one cycle, not issued; next valid op unaffected.
//  6 Steady push+pop each cycle at occupancy 2 for 20 cycles -> occupancy stays 2, output
//    sequence equals input sequence delayed, pointers wrap without loss.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: command encodings, datapath widths and the op bundle.
package alu_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CMD_W  = 3;

    typedef enum logic [CMD_W-1:0] {
        CMD_ADD     = 3'd0,
        CMD_SUB     = 3'd1,
        CMD_AND     = 3'd2,
        CMD_MP0     = 3'd3,
        CMD_MP1     = 3'd4,
        CMD_DIV     = 3'd5,
        CMD_MOD     = 3'd6,
        CMD_ILLEGAL = 3'd7
    } cmd_e;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [CMD_W-1:0]  cmd;
    } op_t;

    localparam int unsigned OP_W = $bits(op_t);

endpackage

// File: rtl/alu_op_fifo.sv
// Generic synchronous FIFO with a registered head word and registered full/empty/count flags.
module alu_op_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2,
    parameter int unsigned W     = 35
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [AW:0]  count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [W-1:0]  head_q, head_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          push_ok;
    logic          pop_ok;
    logic [AW-1:0] rd_next;

    assign push_ok = push_i && !full_q;
    assign pop_ok  = pop_i && !empty_q;
    assign rd_next = rd_ptr_q + AW'(1);

    // Head register shadows mem[rd_ptr]; it is only rewritten when a new entry becomes head.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_next;
        end

        if (push_ok && !pop_ok) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - (AW+1)'(1);
        end

        if (pop_ok) begin
            if (count_q > (AW+1)'(1)) begin
                head_d = mem_q[rd_next];
            end else if (push_ok) begin
                head_d = push_data_i;
            end
        end else if (empty_q && push_ok) begin
            head_d = push_data_i;
        end

        full_d  = (count_d == (AW+1)'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array needs no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = head_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign count_o = count_q;

endmodule

// File: rtl/alu_op_issue.sv
// ALU issue stage: screens incoming ops, buffers legal ones and presents them one at a time.
module alu_op_issue
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [CMD_W-1:0]  in_cmd,
    output logic              alu_valid,
    input  logic              alu_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CMD_W-1:0]  alu_cmd,
    output logic              err_illegal,
    output logic              err_divzero,
    output logic [AW:0]       occupancy
);

    op_t              in_op;
    op_t              head_op;
    logic [OP_W-1:0]  head_bits;
    logic             fifo_full;
    logic             fifo_empty;
    logic             accept;
    logic             is_illegal;
    logic             is_divzero;
    logic             push;
    logic             pop;
    logic             err_illegal_q, err_illegal_d;
    logic             err_divzero_q, err_divzero_d;

    // Divide screen looks at b[15:1] only, the field the ALU divider actually uses.
    always_comb begin
        in_op.a    = in_a;
        in_op.b    = in_b;
        in_op.cmd  = in_cmd;
        accept     = in_valid && !fifo_full;
        is_illegal = (in_cmd == CMD_ILLEGAL);
        is_divzero = ((in_cmd == CMD_DIV) || (in_cmd == CMD_MOD))
                     && (in_b[DATA_W-1:1] == '0);
        push       = accept && !is_illegal && !is_divzero;
        pop        = !fifo_empty && alu_ready;

        err_illegal_d = accept && is_illegal;
        err_divzero_d = accept && is_divzero;
    end

    alu_op_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (OP_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (in_op),
        .pop_i       (pop),
        .head_o      (head_bits),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (occupancy)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_illegal_q <= 1'b0;
            err_divzero_q <= 1'b0;
        end else begin
            err_illegal_q <= err_illegal_d;
            err_divzero_q <= err_divzero_d;
        end
    end

    assign head_op     = op_t'(head_bits);
    assign alu_a       = head_op.a;
    assign alu_b       = head_op.b;
    assign alu_cmd     = head_op.cmd;
    assign alu_valid   = !fifo_empty;
    assign in_ready    = !fifo_full;
    assign err_illegal = err_illegal_q;
    assign err_divzero = err_divzero_q;

endmodule

// File: tb/tb_alu_op_issue.sv
// Bench for alu_op_issue: directed scenarios plus random traffic against a queue-based model.
module tb_alu_op_issue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  c;
    } op_s;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [2:0]  in_cmd;
    logic        alu_valid;
    logic        alu_ready;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_cmd;
    logic        err_illegal;
    logic        err_divzero;
    logic [2:0]  occupancy;

    op_s         q[$];
    logic [15:0] last_a, last_b;
    logic [2:0]  last_c;
    logic        exp_ill, exp_dz;
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    alu_op_issue #(.DEPTH(4), .AW(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_cmd      (in_cmd),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_cmd     (alu_cmd),
        .err_illegal (err_illegal),
        .err_divzero (err_divzero),
        .occupancy   (occupancy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_all();
        check_val("in_ready",    32'(in_ready),    32'(q.size() != DEPTH));
        check_val("alu_valid",   32'(alu_valid),   32'(q.size() != 0));
        check_val("occupancy",   32'(occupancy),   32'(q.size()));
        check_val("alu_a",       32'(alu_a),       32'(last_a));
        check_val("alu_b",       32'(alu_b),       32'(last_b));
        check_val("alu_cmd",     32'(alu_cmd),     32'(last_c));
        check_val("err_illegal", 32'(err_illegal), 32'(exp_ill));
        check_val("err_divzero", 32'(err_divzero), 32'(exp_dz));
    endtask

    task automatic model_reset();
        q.delete();
        last_a  = '0;
        last_b  = '0;
        last_c  = '0;
        exp_ill = 1'b0;
        exp_dz  = 1'b0;
    endtask

    // One clock: drive at negedge, step the model across the posedge, check at next negedge.
    task automatic cycle(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] c, input logic ar);
        logic acc, pop, bad_ill, bad_dz;
        op_s  op;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_cmd    = c;
        alu_ready = ar;
        acc     = v && (q.size() != DEPTH);
        pop     = (q.size() != 0) && ar;
        bad_ill = acc && (c == 3'd7);
        bad_dz  = acc && (c == 3'd5 || c == 3'd6) && (b < 16'd2);
        @(posedge clk);
        if (pop) q.delete(0);
        if (acc && !bad_ill && !bad_dz) begin
            op.a = a;
            op.b = b;
            op.c = c;
            q.push_back(op);
        end
        exp_ill = bad_ill;
        exp_dz  = bad_dz;
        if (q.size() != 0) begin
            last_a = q[0].a;
            last_b = q[0].b;
            last_c = q[0].c;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input logic ar);
        cycle(1'b0, 16'h0, 16'h0, 3'd0, ar);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cmd    = '0;
        alu_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_all();

        // Reset mid-stream with three ops queued
        cycle(1'b1, 16'h1111, 16'h0003, 3'd0, 1'b0);
        cycle(1'b1, 16'h2222, 16'h0004, 3'd1, 1'b0);
        cycle(1'b1, 16'h3333, 16'h0005, 3'd2, 1'b0);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_all();

        // Single op into an empty queue
        cycle(1'b1, 16'h0006, 16'h0004, 3'd0, 1'b1);
        idle(1'b1);

        // Backpressure: five pushes into four slots, then drain
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'(16'h0A00 + i), 16'(16'h0B00 + i), 3'(i), 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Divide screening, illegal command, then a normal op
        cycle(1'b1, 16'h0050, 16'h0001, 3'd5, 1'b0);
        cycle(1'b1, 16'h0051, 16'h0000, 3'd6, 1'b0);
        cycle(1'b1, 16'h0052, 16'h0002, 3'd6, 1'b0);
        cycle(1'b1, 16'hFFFF, 16'hFFFF, 3'd7, 1'b0);
        cycle(1'b1, 16'h0053, 16'h0007, 3'd1, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Steady push+pop at occupancy 2
        cycle(1'b1, 16'h0100, 16'h0200, 3'd0, 1'b0);
        cycle(1'b1, 16'h0101, 16'h0201, 3'd1, 1'b0);
        for (int i = 0; i < 20; i++)
            cycle(1'b1, 16'($urandom), 16'($urandom_range(2, 65535)), 3'($urandom_range(0, 6)), 1'b1);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [15:0] rb;
            rb = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            cycle(1'($urandom_range(0, 3) != 0), 16'($urandom), rb,
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 2) != 0));
        end

        // Async reset again after random traffic
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
